// File: rtl/gpio_bank_arbiter.sv
// gpio_bank_arbiter: round-robin ownership arbiter for one shared GPIO bank.
// Only the granted requester may load the direction/output registers. A hold
// counter limits ownership time, and pad inputs are synchronised for everyone.
module gpio_bank_arbiter #(
  parameter int N       = 8,
  parameter int M       = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [M-1:0]     req,
  input  logic [M-1:0]     rel,
  input  logic [M-1:0]     wr_valid,
  input  logic [M*N-1:0]   wr_dir,
  input  logic [M*N-1:0]   wr_data,
  input  logic [N-1:0]     gpio_in,
  output logic [M-1:0]     gnt,
  output logic             busy,
  output logic [N-1:0]     gpio_out,
  output logic [N-1:0]     gpio_oe,
  output logic [N-1:0]     rd_data,
  output logic             wr_err,
  output logic             timeout_err,
  output logic [$clog2(M)-1:0] err_id
);

  localparam int IDW = $clog2(M);
  localparam int CW  = $clog2(TIMEOUT + 1);
  localparam logic [IDW:0] M_CNT = (IDW + 1)'(M);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN  = 2'd1;
  localparam logic [1:0] ST_TURN = 2'd2;

  logic [1:0]     state_reg, state_next;
  logic [IDW-1:0] owner_reg, owner_next;
  logic [IDW-1:0] last_reg, last_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [M-1:0]   gnt_reg, gnt_next;
  logic [N-1:0]   gpio_out_reg, gpio_oe_reg;
  logic [N-1:0]   sync1_reg, sync2_reg;
  logic           wr_err_reg, timeout_err_reg;
  logic [IDW-1:0] err_id_reg;

  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [IDW:0]   cand;
  logic           bad_found;
  logic [IDW-1:0] bad_idx;
  logic           timeout_hit;
  logic           owner_write;

  // Per-requester views of the flat write buses.
  logic [N-1:0] dir_slice  [M];
  logic [N-1:0] data_slice [M];

  genvar gi;
  generate
    for (gi = 0; gi < M; gi++) begin : g_slice
      assign dir_slice[gi]  = wr_dir[gi*N +: N];
      assign data_slice[gi] = wr_data[gi*N +: N];
    end
  endgenerate

  // Round-robin pick: first requesting index after the previous owner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= M; i++) begin
      cand = {1'b0, last_reg} + (IDW + 1)'(i);
      if (cand >= M_CNT) begin
        cand = cand - M_CNT;
      end
      if (!win_found && req[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDW-1:0];
      end
    end
  end

  // Lowest-index requester writing without ownership (descending scan keeps the lowest).
  always_comb begin
    bad_found = 1'b0;
    bad_idx   = '0;
    for (int k = M - 1; k >= 0; k--) begin
      if (wr_valid[k] && !(state_reg == ST_OWN && IDW'(k) == owner_reg)) begin
        bad_found = 1'b1;
        bad_idx   = IDW'(k);
      end
    end
  end

  assign owner_write = (state_reg == ST_OWN) && wr_valid[owner_reg];

  // Ownership state machine; a voluntary release outranks the hold limit.
  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    last_next   = last_reg;
    cnt_next    = cnt_reg;
    gnt_next    = gnt_reg;
    timeout_hit = 1'b0;
    case (state_reg)
      ST_OWN: begin
        if (rel[owner_reg] || !req[owner_reg]) begin
          state_next = ST_TURN;
          gnt_next   = '0;
        end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
          // This edge closes the TIMEOUT-th granted cycle.
          state_next  = ST_TURN;
          gnt_next    = '0;
          timeout_hit = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        if (win_found) begin
          state_next = ST_OWN;
          owner_next = win_idx;
          last_next  = win_idx;
          cnt_next   = '0;
          gnt_next   = {{(M-1){1'b0}}, 1'b1} << win_idx;
        end else begin
          state_next = ST_IDLE;
          gnt_next   = '0;
        end
      end
    endcase
  end

  // Arbitration registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      owner_reg <= '0;
      last_reg  <= IDW'(M - 1);
      cnt_reg   <= '0;
      gnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
      gnt_reg   <= gnt_next;
    end
  end

  // Bank registers: only the owner loads them; input pins are driven 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_out_reg <= '0;
      gpio_oe_reg  <= '0;
    end else if (owner_write) begin
      gpio_oe_reg  <= dir_slice[owner_reg];
      gpio_out_reg <= data_slice[owner_reg] & dir_slice[owner_reg];
    end
  end

  // Error pulses; a revocation claims err_id over a stray write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_err_reg      <= 1'b0;
      timeout_err_reg <= 1'b0;
      err_id_reg      <= '0;
    end else begin
      wr_err_reg      <= bad_found;
      timeout_err_reg <= timeout_hit;
      if (timeout_hit) begin
        err_id_reg <= owner_reg;
      end else if (bad_found) begin
        err_id_reg <= bad_idx;
      end
    end
  end

  // Two-flop synchroniser for the pad inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= gpio_in;
      sync2_reg <= sync1_reg;
    end
  end

  assign gnt         = gnt_reg;
  assign busy        = (state_reg == ST_OWN);
  assign gpio_out    = gpio_out_reg;
  assign gpio_oe     = gpio_oe_reg;
  assign rd_data     = sync2_reg;
  assign wr_err      = wr_err_reg;
  assign timeout_err = timeout_err_reg;
  assign err_id      = err_id_reg;

endmodule

// File: tb/tb_gpio_bank_arbiter.sv
// Bench for gpio_bank_arbiter: directed scenarios with literal expectations,
// then random traffic, all compared every cycle against a behavioural model.
module tb_gpio_bank_arbiter;

  localparam int N  = 8;
  localparam int M  = 4;
  localparam int TO = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [M-1:0]   req, rel, wr_valid;
  logic [M*N-1:0] wr_dir, wr_data;
  logic [N-1:0]   gpio_in;
  logic [M-1:0]   gnt;
  logic           busy;
  logic [N-1:0]   gpio_out, gpio_oe, rd_data;
  logic           wr_err, timeout_err;
  logic [1:0]     err_id;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  gpio_bank_arbiter #(.N(N), .M(M), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .rel(rel), .wr_valid(wr_valid),
    .wr_dir(wr_dir), .wr_data(wr_data), .gpio_in(gpio_in), .gnt(gnt),
    .busy(busy), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .rd_data(rd_data),
    .wr_err(wr_err), .timeout_err(timeout_err), .err_id(err_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner index (-1 = nobody), plain counters and a 2-deep pipe.
  int         m_owner, m_last, m_hold, m_errid, m_prev, m_off;
  logic [7:0] m_out, m_oe, m_s1, m_s2;
  bit         m_werr, m_terr;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner = -1; m_last = M - 1; m_hold = 0; m_errid = 0;
      m_out = '0; m_oe = '0; m_s1 = '0; m_s2 = '0; m_werr = 0; m_terr = 0;
    end else begin
      m_prev = m_owner;
      m_off  = -1;
      for (int k = M - 1; k >= 0; k--)
        if (wr_valid[k] && k != m_prev) m_off = k;
      m_werr = (m_off >= 0);
      m_terr = 0;
      if (m_prev >= 0 && wr_valid[m_prev]) begin
        m_oe  = wr_dir[m_prev*N +: N];
        m_out = wr_data[m_prev*N +: N] & wr_dir[m_prev*N +: N];
      end
      if (m_prev >= 0) begin
        m_hold++;
        if (rel[m_prev] || !req[m_prev]) m_owner = -1;
        else if (m_hold == TO) begin
          m_owner = -1;
          m_terr  = 1;
        end
      end else begin
        for (int j = 1; j <= M; j++)
          if (m_owner < 0 && req[(m_last + j) % M]) begin
            m_owner = (m_last + j) % M;
            m_last  = m_owner;
            m_hold  = 0;
          end
      end
      if (m_terr) m_errid = m_prev;
      else if (m_werr) m_errid = m_off;
      m_s2 = m_s1;
      m_s1 = gpio_in;
    end
  end

  // Compare process: every output against the model, on the falling edge.
  always @(negedge clk) begin
    if (!reset && chk_en) begin
      chk("gnt", 32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      chk("busy", 32'(busy), 32'(m_owner >= 0));
      chk("gpio_out", 32'(gpio_out), 32'(m_out));
      chk("gpio_oe", 32'(gpio_oe), 32'(m_oe));
      chk("rd_data", 32'(rd_data), 32'(m_s2));
      chk("wr_err", 32'(wr_err), 32'(m_werr));
      chk("timeout_err", 32'(timeout_err), 32'(m_terr));
      chk("err_id", 32'(err_id), 32'(m_errid));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  int exp_order [5] = '{0, 1, 2, 3, 0};
  int hi;
  bit done;

  initial begin
    reset = 1'b0; req = '0; rel = '0; wr_valid = '0;
    wr_dir = '0; wr_data = '0; gpio_in = '0;
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out", 32'(gpio_out), 32'd0);
    chk("rst_oe", 32'(gpio_oe), 32'd0);
    chk("rst_rd", 32'(rd_data), 32'd0);
    chk("rst_errs", {30'd0, wr_err, timeout_err}, 32'd0);
    chk("rst_errid", 32'(err_id), 32'd0);
    reset  = 1'b0;
    chk_en = 1'b1;
    $display("reset: outputs at reset values checked");

    // Grant to requester 0, then an owner write.
    req = 4'b0001;
    cyc();
    chk("grant0", 32'(gnt), 32'h1);
    wr_valid = 4'b0001; wr_dir[7:0] = 8'hF0; wr_data[7:0] = 8'hAA;
    cyc();
    wr_valid = '0;
    chk("write_oe", 32'(gpio_oe), 32'hF0);
    chk("write_out", 32'(gpio_out), 32'hA0);
    $display("write: owner 0 dir=f0 data=aa");

    // Non-owner write from requester 3.
    wr_valid = 4'b1000; wr_dir[31:24] = 8'hFF; wr_data[31:24] = 8'hFF;
    cyc();
    wr_valid = '0;
    chk("werr_pulse", 32'(wr_err), 32'd1);
    chk("werr_id", 32'(err_id), 32'd3);
    chk("werr_out", 32'(gpio_out), 32'hA0);
    cyc();
    chk("werr_single", 32'(wr_err), 32'd0);
    req = '0;
    cyc();
    chk("drop_req", 32'(gnt), 32'd0);
    repeat (2) cyc();
    $display("wr_err: requester 3 rejected");

    // Round-robin hand-over with releases.
    do_reset();
    req = 4'hF;
    for (int t = 0; t < 5; t++) begin
      cyc();
      chk("rr_grant", 32'(gnt), 32'd1 << exp_order[t]);
      chk("rr_busy", 32'(busy), 32'd1);
      cyc();
      rel = 4'(1 << exp_order[t]);
      cyc();
      rel = '0;
      chk("rr_turn_gnt", 32'(gnt), 32'd0);
      chk("rr_turn_busy", 32'(busy), 32'd0);
      $display("rr: owner %0d granted and released", exp_order[t]);
    end
    req = '0;
    repeat (2) cyc();

    // Timeout on requester 1 with requester 2 pending.
    do_reset();
    req = 4'b0010;
    cyc();
    chk("to_grant", 32'(gnt), 32'h2);
    req = 4'b0110;
    hi = 1;
    done = 0;
    for (int w = 0; w < 20; w++) begin
      if (!done) begin
        cyc();
        if (gnt[1]) hi++;
        else done = 1;
      end
    end
    chk("to_hold_cycles", 32'(hi), 32'd4);
    chk("to_pulse", 32'(timeout_err), 32'd1);
    chk("to_errid", 32'(err_id), 32'd1);
    chk("to_turn", 32'(gnt), 32'd0);
    cyc();
    chk("to_next", 32'(gnt), 32'h4);
    chk("to_single", 32'(timeout_err), 32'd0);
    $display("timeout: owner 1 held %0d cycles, requester 2 next", hi);

    // Write and release together, then retention through IDLE.
    wr_valid = 4'b0100; wr_dir[23:16] = 8'h0F; wr_data[23:16] = 8'h0F;
    rel = 4'b0100; req = '0;
    cyc();
    wr_valid = '0; rel = '0;
    chk("wrel_oe", 32'(gpio_oe), 32'h0F);
    chk("wrel_out", 32'(gpio_out), 32'h0F);
    chk("wrel_gnt", 32'(gnt), 32'd0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("retain_oe", 32'(gpio_oe), 32'h0F);
      chk("retain_out", 32'(gpio_out), 32'h0F);
    end
    $display("write+release: values retained for 10 idle cycles");

    // Synchroniser latency.
    gpio_in = 8'h5A;
    cyc();
    chk("rd_lat1", 32'(rd_data), 32'h00);
    cyc();
    chk("rd_lat2", 32'(rd_data), 32'h5A);
    $display("sync: rd_data 5a after 2 cycles");

    // Asynchronous reset during ownership.
    req = 4'b0001;
    cyc();
    chk("pre_rst_gnt", 32'(gnt), 32'h1);
    wr_valid = 4'b0001; wr_dir[7:0] = 8'hFF; wr_data[7:0] = 8'h3C;
    cyc();
    wr_valid = '0;
    chk("pre_rst_out", 32'(gpio_out), 32'h3C);
    #2 reset = 1'b1;
    #1;
    chk("arst_gnt", 32'(gnt), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_oe", 32'(gpio_oe), 32'd0);
    chk("arst_out", 32'(gpio_out), 32'd0);
    req = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    req = 4'b0011;
    cyc();
    chk("restart_prio", 32'(gnt), 32'h1);
    req = '0;
    repeat (2) cyc();
    $display("async reset: outputs cleared mid-cycle, priority restarts at 0");

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < M; k++) begin
        if ($urandom_range(7) == 0) req[k] = ~req[k];
        rel[k]      = ($urandom_range(9) == 0);
        wr_valid[k] = ($urandom_range(5) == 0);
      end
      if (m_owner >= 0 && $urandom_range(2) == 0) wr_valid[m_owner] = 1'b1;
      wr_dir  = $urandom;
      wr_data = $urandom;
      if ($urandom_range(3) == 0) gpio_in = 8'($urandom);
      if (c % 700 == 699) begin
        reset = 1'b1;
        #1 reset = 1'b0;
      end
      cyc();
    end
    $display("random: 3000 cycles of traffic");

    cyc();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
